// File: rtl/xviterbi_dec.sv
// rtl/xviterbi_dec.sv - hard-decision K=7 rate-1/2 Viterbi decoder
// 64-state ACS with modulo path metrics and register-exchange survivors, output from state 0.
module xviterbi_dec #(
   parameter int TB_DEPTH = 48,
   parameter int PM_W     = 7,
   parameter int INIT_PM  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dec_en,
   input  logic [1:0] bits_in,
   output logic       bit_out,
   output logic       bit_valid
);

   localparam int CNT_W = $clog2(TB_DEPTH + 1);

   logic [PM_W-1:0]     pm_q   [64];
   logic [PM_W-1:0]     pm_d   [64];
   logic [TB_DEPTH-1:0] surv_q [64];
   logic [TB_DEPTH-1:0] surv_d [64];
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                bit_out_q, bit_out_d;
   logic                bit_valid_q, bit_valid_d;

   function automatic logic [1:0] exp_sym(input logic [5:0] p, input logic b);
      return {b ^ p[1] ^ p[2] ^ p[4] ^ p[5], b ^ p[0] ^ p[1] ^ p[2] ^ p[5]};
   endfunction

   function automatic logic [1:0] popcnt2(input logic [1:0] x);
      return {x[1] & x[0], x[1] ^ x[0]};
   endfunction

   always_comb begin
      logic [5:0]          p0, p1;
      logic                b;
      logic [PM_W-1:0]     c0, c1, diff;
      logic                sel;
      logic [TB_DEPTH-1:0] sv;
      p0          = '0;
      p1          = '0;
      b           = 1'b0;
      c0          = '0;
      c1          = '0;
      diff        = '0;
      sel         = 1'b0;
      sv          = '0;
      pm_d        = pm_q;
      surv_d      = surv_q;
      cnt_d       = cnt_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
      if (dec_en) begin
         for (int n = 0; n < 64; n++) begin
            b  = 1'(n & 1);
            p0 = {1'b0, 5'(n >> 1)};
            p1 = {1'b1, 5'(n >> 1)};
            c0 = pm_q[p0] + PM_W'(popcnt2(exp_sym(p0, b) ^ bits_in));
            c1 = pm_q[p1] + PM_W'(popcnt2(exp_sym(p1, b) ^ bits_in));
            // Modulo compare: c0-c1 read as signed; only a strictly positive difference picks p1.
            diff = c0 - c1;
            sel  = !diff[PM_W-1] && (diff != '0);
            sv   = sel ? surv_q[p1] : surv_q[p0];
            pm_d[n]   = sel ? c1 : c0;
            surv_d[n] = {sv[TB_DEPTH-2:0], b};
         end
         cnt_d = (cnt_q == CNT_W'(TB_DEPTH)) ? cnt_q : cnt_q + 1'b1;
         if (cnt_d == CNT_W'(TB_DEPTH)) begin
            bit_out_d   = surv_d[0][TB_DEPTH-1];
            bit_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) begin
            pm_q[i]   <= (i == 0) ? '0 : PM_W'(INIT_PM);
            surv_q[i] <= '0;
         end
         cnt_q       <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
      end else begin
         pm_q        <= pm_d;
         surv_q      <= surv_d;
         cnt_q       <= cnt_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
      end
   end

   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;

endmodule

// File: tb/tb_xviterbi_dec.sv
// tb/tb_xviterbi_dec.sv - directed self-checking bench for xviterbi_dec
// Reference convolutional encoder feeds the decoder; decoded bits are compared to the delayed input.
module tb_xviterbi_dec;

   logic       clk = 1'b0;
   logic       rst;
   logic       dec_en;
   logic [1:0] bits_in;
   logic       bit_out;
   logic       bit_valid;

   always #5 clk = ~clk;

   xviterbi_dec dut (
      .clk       (clk),
      .rst       (rst),
      .dec_en    (dec_en),
      .bits_in   (bits_in),
      .bit_out   (bit_out),
      .bit_valid (bit_valid)
   );

   int         n_chk = 0;
   int         n_pass = 0;
   bit         hist [0:6999];
   bit         rbits [0:999];
   int         sym_idx;
   logic [5:0] enc_s;
   int         valid_err, bit_err, nout, first_valid, first_bit;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic clr_stats();
      valid_err   = 0;
      bit_err     = 0;
      nout        = 0;
      first_valid = -1;
      first_bit   = -1;
   endtask

   task automatic step(input logic [1:0] sym, input bit truth);
      sym_idx++;
      hist[sym_idx] = truth;
      dec_en  = 1'b1;
      bits_in = sym;
      @(posedge clk);
      #1;
      dec_en = 1'b0;
      if (bit_valid !== (sym_idx >= 48)) valid_err++;
      if (bit_valid === 1'b1) begin
         nout++;
         if (first_valid < 0) begin
            first_valid = sym_idx;
            first_bit   = int'(bit_out);
         end
         if (sym_idx >= 48 && bit_out !== hist[sym_idx-47]) bit_err++;
      end
   endtask

   task automatic enc(input bit b, input bit flip);
      logic [1:0] sym;
      sym = {b ^ enc_s[1] ^ enc_s[2] ^ enc_s[4] ^ enc_s[5],
             b ^ enc_s[0] ^ enc_s[1] ^ enc_s[2] ^ enc_s[5]};
      enc_s = {enc_s[4:0], b};
      if (flip) sym = sym ^ ((sym_idx % 2 == 0) ? 2'b01 : 2'b10);
      step(sym, b);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bit_valid !== 1'b0) valid_err++;
      end
   endtask

   task automatic do_reset(input string tag, input bit with_en);
      rst     = 1'b1;
      dec_en  = with_en;
      bits_in = 2'b11;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      dec_en = 1'b0;
      check({tag, "_rst_valid"}, int'(bit_valid), 0);
      check({tag, "_rst_out"}, int'(bit_out), 0);
      sym_idx = 0;
      enc_s   = '0;
   endtask

   task automatic report(input string tag, input int exp_nout);
      check({tag, "_valid_err"}, valid_err, 0);
      check({tag, "_bit_err"}, bit_err, 0);
      check({tag, "_nout"}, nout, exp_nout);
      check({tag, "_first_valid"}, first_valid, 48);
   endtask

   logic [1:0] t2_tab [0:6];

   initial begin
      rst     = 1'b1;
      dec_en  = 1'b0;
      bits_in = 2'b00;
      sym_idx = 0;
      enc_s   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("init_valid", int'(bit_valid), 0);
      check("init_out", int'(bit_out), 0);
      rst = 1'b0;

      // T1: all-zero symbols
      clr_stats();
      for (int i = 0; i < 200; i++) enc(1'b0, 1'b0);
      report("t1", 153);

      // T2: impulse response sent from a hand-written table
      do_reset("t2", 1'b0);
      clr_stats();
      t2_tab = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
      for (int i = 0; i < 7; i++) step(t2_tab[i], i == 0);
      for (int i = 0; i < 60; i++) step(2'b00, 1'b0);
      report("t2", 20);
      check("t2_first_bit", first_bit, 1);

      // T3: random error-free stream
      do_reset("t3", 1'b0);
      clr_stats();
      for (int i = 0; i < 1000; i++) begin
         rbits[i] = 1'($urandom_range(0, 1));
         enc(rbits[i], 1'b0);
      end
      report("t3", 953);

      // T4: same stream with one flipped bit every 20 symbols
      do_reset("t4", 1'b0);
      clr_stats();
      for (int i = 0; i < 1000; i++) enc(rbits[i], (i % 20) == 19);
      report("t4", 953);

      // T5: gapped strobes, bursts, and reset with dec_en high at symbol 300
      do_reset("t5", 1'b0);
      clr_stats();
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            report("t5a", 253);
            do_reset("t5b", 1'b1);
            clr_stats();
         end
         if (((i / 40) % 2) == 1) idle($urandom_range(0, 5));
         enc(1'($urandom_range(0, 1)), 1'b0);
      end
      report("t5b", 253);

      // T6: all-ones input with errors every 7th symbol, metrics wrap many times
      do_reset("t6", 1'b0);
      clr_stats();
      for (int i = 0; i < 5000; i++) enc(1'b1, (i % 7) == 6);
      report("t6", 4953);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
